// File: rtl/seg_disp_ctrl.sv
// seg_disp_ctrl: selects the seven-segment display source, runs the error countdown and latches op/matrix values.
module seg_disp_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CD_MIN   = 5,
  parameter int CD_MAX   = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sys_mode,
  input  logic       err_start,
  input  logic [3:0] cd_cfg,
  input  logic       cd_abort,
  input  logic       sel_strobe,
  input  logic [2:0] op_sel_in,
  input  logic [3:0] matrix_id_in,
  output logic [1:0] mode_sel,
  output logic [2:0] op_sel,
  output logic [7:0] countdown_val,
  output logic [3:0] matrix_id_out,
  output logic       cd_busy,
  output logic       cd_done
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {FOLLOW, COUNT, DONE} state_t;
  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    cd_val_q, cd_val_d, cfg_ext, load_val;
  logic [1:0]    mode_sel_q, mode_sel_d;
  logic [2:0]    op_sel_q, op_sel_d;
  logic [3:0]    mid_q, mid_d;
  logic          busy_q, busy_d, done_q, done_d, tick_end, start, latch;
  always_comb begin
    cfg_ext  = {4'b0, cd_cfg};
    load_val = cfg_ext < 8'(CD_MIN) ? 8'(CD_MIN) : cfg_ext > 8'(CD_MAX) ? 8'(CD_MAX) : cfg_ext;
    tick_end = tick_q == TW'(TICK_DIV - 1);
    start    = err_start && !cd_abort;
    state_d  = state_q;
    tick_d   = '0;
    cd_val_d = '0;
    case (state_q)
      FOLLOW: if (start) begin
        state_d  = COUNT;
        cd_val_d = load_val;
      end
      COUNT: begin
        // abort beats restart, restart beats the tick decrement
        if (cd_abort) state_d = FOLLOW;
        else if (err_start) cd_val_d = load_val;
        else if (tick_end) begin
          cd_val_d = cd_val_q - 8'd1;
          state_d  = cd_val_q == 8'd1 ? DONE : COUNT;
        end else begin
          cd_val_d = cd_val_q;
          tick_d   = tick_q + 1'b1;
        end
      end
      default: begin
        state_d  = start ? COUNT : FOLLOW;
        cd_val_d = start ? load_val : 8'd0;
      end
    endcase
    mode_sel_d = state_d == FOLLOW ? sys_mode : 2'b00;
    busy_d     = state_d == COUNT;
    done_d     = state_d == DONE;
    latch      = sel_strobe && sys_mode == 2'b11;
    op_sel_d   = latch ? op_sel_in : op_sel_q;
    mid_d      = latch ? matrix_id_in : mid_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FOLLOW;
      tick_q     <= '0;
      cd_val_q   <= '0;
      mode_sel_q <= '0;
      op_sel_q   <= '0;
      mid_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      cd_val_q   <= cd_val_d;
      mode_sel_q <= mode_sel_d;
      op_sel_q   <= op_sel_d;
      mid_q      <= mid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end
  assign mode_sel      = mode_sel_q;
  assign op_sel        = op_sel_q;
  assign countdown_val = cd_val_q;
  assign matrix_id_out = mid_q;
  assign cd_busy       = busy_q;
  assign cd_done       = done_q;
endmodule

// File: tb/tb_seg_disp_ctrl.sv
// tb_seg_disp_ctrl: directed vectors against an elapsed-time model of the countdown and latch path.
module tb_seg_disp_ctrl;
  localparam int TD = 10;
  logic       clk = 0, rst_n = 1;
  logic [1:0] sys_mode = 0;
  logic       err_start = 0, cd_abort = 0, sel_strobe = 0;
  logic [3:0] cd_cfg = 0, matrix_id_in = 0;
  logic [2:0] op_sel_in = 0;
  logic [1:0] mode_sel;
  logic [2:0] op_sel;
  logic [7:0] countdown_val;
  logic [3:0] matrix_id_out;
  logic       cd_busy, cd_done;
  int vectors = 0, errors = 0;

  always #5 clk = ~clk;

  seg_disp_ctrl #(.TICK_DIV(TD), .CD_MIN(5), .CD_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .sys_mode(sys_mode), .err_start(err_start), .cd_cfg(cd_cfg),
    .cd_abort(cd_abort), .sel_strobe(sel_strobe), .op_sel_in(op_sel_in), .matrix_id_in(matrix_id_in),
    .mode_sel(mode_sel), .op_sel(op_sel), .countdown_val(countdown_val), .matrix_id_out(matrix_id_out),
    .cd_busy(cd_busy), .cd_done(cd_done)
  );

  // model: a countdown is "load value at edge t0"; remaining = load - elapsed/TD
  int   cyc = 0, m_load = 0, m_t0 = 0;
  bit   m_act = 0, m_done = 0;
  logic [1:0] m_mode = 0;
  logic [2:0] m_op = 0;
  logic [3:0] m_mid = 0;
  bit   start_hit, expire;

  function automatic int clampf(input int c);
    return c < 5 ? 5 : (c > 15 ? 15 : c);
  endfunction

  assign start_hit = err_start && !cd_abort;
  assign expire    = m_act && !cd_abort && !err_start && (cyc + 1 - m_t0 == m_load * TD);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 0; m_done <= 0; m_load <= 0; m_t0 <= 0;
      m_mode <= 0; m_op <= 0; m_mid <= 0;
    end else begin
      cyc    <= cyc + 1;
      m_act  <= start_hit ? 1'b1 : (cd_abort || expire) ? 1'b0 : m_act;
      m_done <= expire;
      m_load <= start_hit ? clampf(int'(cd_cfg)) : m_load;
      m_t0   <= start_hit ? cyc + 1 : m_t0;
      m_mode <= (start_hit || (m_act && !cd_abort)) ? 2'b00 : sys_mode;
      if (sel_strobe && sys_mode == 2'b11) begin
        m_op  <= op_sel_in;
        m_mid <= matrix_id_in;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("mdl_val", int'(countdown_val), m_act ? m_load - (cyc - m_t0) / TD : 0);
      chk("mdl_busy", int'(cd_busy), int'(m_act));
      chk("mdl_done", int'(cd_done), int'(m_done));
      chk("mdl_mode", int'(mode_sel), int'(m_mode));
      chk("mdl_op", int'(op_sel), int'(m_op));
      chk("mdl_mid", int'(matrix_id_out), int'(m_mid));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [3:0] cfg);
    cd_cfg = cfg; err_start = 1; tick(1); err_start = 0;
  endtask

  task automatic abort1();
    cd_abort = 1; tick(1); cd_abort = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_val"}, int'(countdown_val), 0);
    chk({tag, "_busy"}, int'(cd_busy), 0);
    chk({tag, "_done"}, int'(cd_done), 0);
    chk({tag, "_mode"}, int'(mode_sel), 0);
    chk({tag, "_op"}, int'(op_sel), 0);
    chk({tag, "_mid"}, int'(matrix_id_out), 0);
  endtask

  initial begin
    #1 rst_n = 0;
    #1 chk_zero("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    sys_mode = 2'd2; tick(1);
    chk("follow_mode", int'(mode_sel), 2);
    // basic 7 s countdown
    go(4'd7);
    chk("load7", int'(countdown_val), 7);
    chk("load7_busy", int'(cd_busy), 1);
    chk("load7_mode", int'(mode_sel), 0);
    tick(9);  chk("pre_dec", int'(countdown_val), 7);
    tick(1);  chk("first_dec", int'(countdown_val), 6);
    tick(59); chk("last1", int'(countdown_val), 1);
    chk("last1_done", int'(cd_done), 0);
    tick(1);  chk("done_pulse", int'(cd_done), 1);
    chk("done_val", int'(countdown_val), 0);
    chk("done_busy", int'(cd_busy), 0);
    chk("done_mode", int'(mode_sel), 0);
    tick(1);  chk("done_clear", int'(cd_done), 0);
    chk("back_follow", int'(mode_sel), 2);
    // clamping
    go(4'd2);  chk("clamp2", int'(countdown_val), 5);
    tick(3);
    go(4'd15); chk("clamp15", int'(countdown_val), 15);
    tick(3);
    go(4'd0);  chk("clamp0", int'(countdown_val), 5);
    abort1();  chk("abort_val", int'(countdown_val), 0);
    chk("abort_busy", int'(cd_busy), 0);
    // restart at 3, then abort at 4
    go(4'd7); tick(40); chk("at3", int'(countdown_val), 3);
    go(4'd6); chk("restart", int'(countdown_val), 6);
    tick(9);  chk("restart_hold", int'(countdown_val), 6);
    tick(1);  chk("restart_dec", int'(countdown_val), 5);
    tick(10); chk("at4", int'(countdown_val), 4);
    abort1(); chk("abort4_val", int'(countdown_val), 0);
    chk("abort4_busy", int'(cd_busy), 0);
    tick(5);
    // same-cycle start and abort
    go(4'd8); tick(5);
    cd_abort = 1; go(4'd12); cd_abort = 0;
    chk("both_val", int'(countdown_val), 0);
    chk("both_busy", int'(cd_busy), 0);
    tick(1); chk("both_mode", int'(mode_sel), 2);
    // restart on the tick-terminal cycle
    go(4'd7); tick(9);
    go(4'd9); chk("term_reload", int'(countdown_val), 9);
    tick(9);  chk("term_hold", int'(countdown_val), 9);
    tick(1);  chk("term_dec", int'(countdown_val), 8);
    abort1();
    // restart during DONE
    go(4'd5); tick(50);
    chk("done2", int'(cd_done), 1);
    go(4'd11);
    chk("done2_busy", int'(cd_busy), 1);
    chk("done2_val", int'(countdown_val), 11);
    chk("done2_clr", int'(cd_done), 0);
    abort1();
    // latch gating
    sys_mode = 2'd3; op_sel_in = 3'd3; matrix_id_in = 4'd2;
    sel_strobe = 1; tick(1); sel_strobe = 0;
    chk("latch_op", int'(op_sel), 3);
    chk("latch_mid", int'(matrix_id_out), 2);
    sys_mode = 2'd1; op_sel_in = 3'd5; matrix_id_in = 4'd9;
    sel_strobe = 1; tick(1); sel_strobe = 0;
    chk("gate_op", int'(op_sel), 3);
    chk("gate_mid", int'(matrix_id_out), 2);
    sys_mode = 2'd3; sel_strobe = 1; tick(1); sel_strobe = 0;
    chk("latch5_op", int'(op_sel), 5);
    chk("latch9_mid", int'(matrix_id_out), 9);
    op_sel_in = 3'd1; tick(2);
    chk("hold_op", int'(op_sel), 5);
    // async reset mid-countdown at 9
    go(4'd9); tick(3);
    chk("pre_rst", int'(countdown_val), 9);
    #2 rst_n = 0;
    #1 chk_zero("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    sys_mode = 2'd1; tick(1);
    chk("post_rst_mode", int'(mode_sel), 1);
    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
